// File: rtl/alu_sevenseg_scan.sv
// Registered WIDTH-bit ALU feeding a one-hot scanned, multi-digit hex display.
// Digit 0 shows the least-significant nibble of the result register.
module alu_sevenseg_scan #(
   parameter int WIDTH       = 8,
   parameter int REFRESH_DIV = 4,
   localparam int DIGITS     = (WIDTH + 3) / 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WIDTH-1:0]  in0,
   input  logic [WIDTH-1:0]  in1,
   input  logic [1:0]        opcode,
   input  logic              load,
   input  logic              enable,
   output logic [WIDTH-1:0]  result,
   output logic              flag,
   output logic              valid,
   output logic [6:0]        seg,
   output logic [DIGITS-1:0] digit_sel
);

   localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

   logic [WIDTH:0]      sum;
   logic [WIDTH:0]      diff;
   logic [WIDTH-1:0]    alu_res;
   logic                alu_flag;
   logic [DIV_W-1:0]    div;
   logic [IDX_W-1:0]    idx;
   logic [4*DIGITS-1:0] padded;
   logic [3:0]          nib;
   logic [6:0]          dec;

   // The borrow of a WIDTH+1 bit subtraction is exactly in0 < in1.
   always_comb begin
      sum      = {1'b0, in0} + {1'b0, in1};
      diff     = {1'b0, in0} - {1'b0, in1};
      alu_res  = '0;
      alu_flag = 1'b0;
      unique case (opcode)
         2'b00: {alu_flag, alu_res} = sum;
         2'b01: alu_res = in0 | in1;
         2'b10: begin
            alu_res  = diff[WIDTH-1:0];
            alu_flag = diff[WIDTH];
         end
         default: alu_res = in0 ^ in1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result <= '0;
         flag   <= 1'b0;
         valid  <= 1'b0;
      end else begin
         valid <= load;
         if (load) begin
            result <= alu_res;
            flag   <= alu_flag;
         end
      end
   end

   // Scan restarts at digit 0 with a full dwell whenever enable drops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div <= '0;
         idx <= '0;
      end else if (!enable) begin
         div <= '0;
         idx <= '0;
      end else if (div == DIV_LAST) begin
         div <= '0;
         idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
         div <= div + 1'b1;
      end
   end

   assign padded = (4 * DIGITS)'(result);

   always_comb begin
      nib = 4'h0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx == IDX_W'(i)) nib = padded[i*4 +: 4];
      end
   end

   always_comb begin
      dec = 7'h00;
      unique case (nib)
         4'h0: dec = 7'h7E;
         4'h1: dec = 7'h30;
         4'h2: dec = 7'h6D;
         4'h3: dec = 7'h79;
         4'h4: dec = 7'h33;
         4'h5: dec = 7'h5B;
         4'h6: dec = 7'h5F;
         4'h7: dec = 7'h70;
         4'h8: dec = 7'h7F;
         4'h9: dec = 7'h7B;
         4'hA: dec = 7'h77;
         4'hB: dec = 7'h1F;
         4'hC: dec = 7'h4E;
         4'hD: dec = 7'h3D;
         4'hE: dec = 7'h4F;
         default: dec = 7'h47;
      endcase
   end

   assign seg       = enable ? dec : 7'h00;
   assign digit_sel = enable ? (DIGITS'(1) << idx) : '0;

endmodule

// File: tb/tb_alu_sevenseg_scan.sv
// Randomized bench for alu_sevenseg_scan: an 8-bit/div-4 instance and a
// 5-bit/div-1 instance, both checked against an arithmetic reference model.
module tb_alu_sevenseg_scan;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic [7:0] a_in0, a_in1, a_res;
   logic [1:0] a_op;
   logic       a_load, a_en, a_flag, a_valid;
   logic [6:0] a_seg;
   logic [1:0] a_sel;

   logic [4:0] b_in0, b_in1, b_res;
   logic [1:0] b_op;
   logic       b_load, b_en, b_flag, b_valid;
   logic [6:0] b_seg;
   logic [1:0] b_sel;

   alu_sevenseg_scan #(.WIDTH(8), .REFRESH_DIV(4)) u_a (
      .clk(clk), .rst_n(rst_n), .in0(a_in0), .in1(a_in1),
      .opcode(a_op), .load(a_load), .enable(a_en),
      .result(a_res), .flag(a_flag), .valid(a_valid),
      .seg(a_seg), .digit_sel(a_sel));

   alu_sevenseg_scan #(.WIDTH(5), .REFRESH_DIV(1)) u_b (
      .clk(clk), .rst_n(rst_n), .in0(b_in0), .in1(b_in1),
      .opcode(b_op), .load(b_load), .enable(b_en),
      .result(b_res), .flag(b_flag), .valid(b_valid),
      .seg(b_seg), .digit_sel(b_sel));

   logic [6:0] tbl [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B,
      7'h5F, 7'h70, 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F,
      7'h47};

   int n_checks = 0;
   int n_fail   = 0;

   int m_a_res, m_a_flag, m_a_val, m_a_n;
   int m_b_res, m_b_flag, m_b_val, m_b_n;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int alu_ref(int w, int a, int b, logic [1:0] op);
      int mask, r, f;
      mask = (1 << w) - 1;
      f = 0;
      case (op)
         2'd0: begin r = a + b; f = (r >> w) & 1; end
         2'd1: r = a | b;
         2'd2: begin r = a - b; f = (a < b) ? 1 : 0; end
         default: r = a ^ b;
      endcase
      return (f << 16) | (r & mask);
   endfunction

   function automatic int pos_a();
      return (m_a_n / 4) % 2;
   endfunction

   function automatic int pos_b();
      return m_b_n % 2;
   endfunction

   task automatic check_disp();
      int p;
      if (a_en) begin
         p = pos_a();
         chk("a_sel", 32'(a_sel), 32'(1 << p));
         chk("a_seg", 32'(a_seg), 32'(tbl[(m_a_res >> (4 * p)) & 15]));
      end else begin
         chk("a_sel_off", 32'(a_sel), 0);
         chk("a_seg_off", 32'(a_seg), 0);
      end
      if (b_en) begin
         p = pos_b();
         chk("b_sel", 32'(b_sel), 32'(1 << p));
         chk("b_seg", 32'(b_seg), 32'(tbl[(m_b_res >> (4 * p)) & 15]));
      end else begin
         chk("b_sel_off", 32'(b_sel), 0);
         chk("b_seg_off", 32'(b_seg), 0);
      end
   endtask

   task automatic check_all();
      chk("a_res", 32'(a_res), 32'(m_a_res));
      chk("a_flag", 32'(a_flag), 32'(m_a_flag));
      chk("a_valid", 32'(a_valid), 32'(m_a_val));
      chk("b_res", 32'(b_res), 32'(m_b_res));
      chk("b_flag", 32'(b_flag), 32'(m_b_flag));
      chk("b_valid", 32'(b_valid), 32'(m_b_val));
      check_disp();
   endtask

   task automatic model_reset();
      m_a_res = 0; m_a_flag = 0; m_a_val = 0; m_a_n = 0;
      m_b_res = 0; m_b_flag = 0; m_b_val = 0; m_b_n = 0;
   endtask

   task automatic tick();
      int r;
      @(posedge clk);
      if (a_load) begin
         r = alu_ref(8, int'(a_in0), int'(a_in1), a_op);
         m_a_res = r & 16'hFFFF; m_a_flag = r >> 16;
      end
      m_a_val = a_load ? 1 : 0;
      m_a_n   = a_en ? m_a_n + 1 : 0;
      if (b_load) begin
         r = alu_ref(5, int'(b_in0), int'(b_in1), b_op);
         m_b_res = r & 16'hFFFF; m_b_flag = r >> 16;
      end
      m_b_val = b_load ? 1 : 0;
      m_b_n   = b_en ? m_b_n + 1 : 0;
      #1;
      check_all();
   endtask

   task automatic async_reset();
      #2 rst_n = 1'b0;
      #1 model_reset();
      chk("rst_res", 32'(a_res), 0);
      chk("rst_valid", 32'(a_valid), 0);
      chk("rst_flag", 32'(a_flag), 0);
      check_disp();
      #1 rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      a_in0 = '0; a_in1 = '0; a_op = '0; a_load = 0; a_en = 1;
      b_in0 = '0; b_in1 = '0; b_op = '0; b_load = 0; b_en = 1;
      model_reset();
      #2;
      chk("init_sel", 32'(a_sel), 32'h1);
      chk("init_seg", 32'(a_seg), 32'h7E);
      check_all();
      @(negedge clk) rst_n = 1'b1;

      a_in0 = 8'h9C; a_in1 = 8'h7A; a_op = 2'b00; a_load = 1;
      tick();
      chk("add_res", 32'(a_res), 32'h16);
      chk("add_flag", 32'(a_flag), 1);
      chk("add_valid", 32'(a_valid), 1);
      async_reset();
      chk("rst_sel", 32'(a_sel), 32'h1);
      chk("rst_seg", 32'(a_seg), 32'h7E);

      tick();
      a_load = 0;
      tick();
      chk("valid_drop", 32'(a_valid), 0);
      for (int i = 0; i < 8; i++) begin
         if (pos_a() == 0) chk("d0_seg", 32'(a_seg), 32'h5F);
         else chk("d1_seg", 32'(a_seg), 32'h30);
         tick();
      end

      a_in0 = 8'h05; a_in1 = 8'h07; a_op = 2'b10; a_load = 1;
      tick();
      chk("sub_res", 32'(a_res), 32'hFE);
      chk("sub_flag", 32'(a_flag), 1);
      a_in0 = 8'hF0; a_in1 = 8'h0F; a_op = 2'b11;
      tick();
      chk("xor_res", 32'(a_res), 32'hFF);
      chk("xor_flag", 32'(a_flag), 0);
      chk("b2b_valid", 32'(a_valid), 1);
      a_load = 0;
      tick();

      for (int i = 0; i < 8 && pos_a() != 1; i++) tick();
      chk("pre_drop_sel", 32'(a_sel), 32'h2);
      a_en = 0;
      #1;
      chk("drop_sel", 32'(a_sel), 0);
      chk("drop_seg", 32'(a_seg), 0);
      tick();
      a_en = 1;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk("reen_sel", 32'(a_sel), 32'h1);
         tick();
      end
      chk("reen_next", 32'(a_sel), 32'h2);

      b_in0 = 5'h1F; b_in1 = 5'h00; b_op = 2'b01; b_load = 1;
      tick();
      b_load = 0;
      chk("b_or_res", 32'(b_res), 32'h1F);
      for (int i = 0; i < 2; i++) begin
         if (pos_b() == 0) chk("b_d0", 32'(b_seg), 32'h47);
         else chk("b_d1", 32'(b_seg), 32'h30);
         tick();
      end

      for (int i = 0; i < 400; i++) begin
         a_in0  = 8'($urandom);
         a_in1  = 8'($urandom);
         a_op   = 2'($urandom);
         a_load = ($urandom_range(0, 2) != 0);
         a_en   = ($urandom_range(0, 9) != 0);
         b_in0  = 5'($urandom);
         b_in1  = 5'($urandom);
         b_op   = 2'($urandom);
         b_load = ($urandom_range(0, 1) != 0);
         b_en   = ($urandom_range(0, 7) != 0);
         tick();
         if ($urandom_range(0, 59) == 0) async_reset();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_sevenseg_scan.md
Name: alu_sevenseg_scan

Overview:
Parametrised successor of the team's 4-bit ALU + single-digit 7-segment decoder. Operands of WIDTH bits are captured on a load strobe and the result is registered. The registered result drives a time-multiplexed, one-hot-scanned hex display of DIGITS digits. The block sits between the operand/control logic and the board's common-cathode multi-digit display.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1).
- REFRESH_DIV, 4, clocks each digit stays selected (>=1).
- DIGITS, derived localparam (WIDTH+3)/4, not overridable.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in0  input  WIDTH  operand A.
- in1  input  WIDTH  operand B.
- opcode  input  2  00 add, 01 OR, 10 subtract, 11 XOR.
- load  input  1  capture operands/opcode and compute this cycle.
- enable  input  1  display enable.
- result  output  WIDTH  registered ALU result.
- flag  output  1  registered carry (add) / borrow (sub); 0 for OR/XOR.
- valid  output  1  one-cycle pulse: result/flag updated.
- seg  output  7  {a,b,c,d,e,f,g}, a = MSB, active-high.
- digit_sel  output  DIGITS  one-hot digit select, bit0 = least-significant nibble.

Behaviour:
- Reset (rst_n=0, asynchronous): result=0, flag=0, valid=0, divider=0, scan index=0. With enable=1 the display shows "0" on digit 0 immediately after reset.
- ALU: on a rising edge with load=1, result and flag take the value computed from the current in0/in1/opcode, and valid=1 for that one cycle. Latency is 1 clock.
  - When load=0, result and flag hold and valid=0.
  - Back-to-back loads are each captured, and valid stays high.
- Arithmetic:
  - add: {flag,result} = in0+in1, WIDTH+1 bits.
  - sub: result = (in0-in1) mod 2^WIDTH; flag=1 iff in0<in1.
  - OR/XOR: bitwise; flag=0.
- Scan divider: counts 0..REFRESH_DIV-1 while enable=1. At terminal count it wraps to 0 and the scan index increments mod DIGITS (DIGITS-1 -> 0).
  - With REFRESH_DIV=1 the index advances every clock.
  - With DIGITS=1 the index stays 0.
- enable=0:
  - seg=0 and digit_sel=0, combinationally.
  - Divider and index are synchronously cleared to 0.
  - On re-enable, scanning restarts at digit 0 with a full REFRESH_DIV dwell.
- Display outputs are combinational from the scan index, result register and enable.
  - digit_sel = 1<<index.
  - seg = decode(nibble[index] of result).
  - If WIDTH is not a multiple of 4, the top nibble is zero-extended.
- Decode table (hex, {a..g}): 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B A=77 B=1F C=4E D=3D E=4F F=47.
- Independence: a load during scanning updates the shown digits from the next cycle and does not disturb divider or index. A load with enable=0 still updates result.
- Reset asserted mid-scan or mid-load forces all reset values at once, without waiting for a clock.

Test Plan (WIDTH=8, REFRESH_DIV=4):
- Assert rst_n=0 asynchronously between edges, enable=1 -> immediately result=00, flag=0, valid=0, digit_sel=01, seg=7E.
- load=1 for 1 cycle with in0=9C, in1=7A, opcode=00 -> next edge: result=16, flag=1, valid=1 for exactly 1 cycle. Digit 0 shows seg=5F, digit 1 shows seg=30.
- load=1 with in0=05, in1=07, opcode=10 -> result=FE, flag=1. Then in0=F0, in1=0F, opcode=11 -> result=FF, flag=0. Back-to-back loads keep valid=1 for both cycles.
- enable=1 held -> digit_sel = 01 for 4 clocks, then 10 for 4 clocks, then 01 (wrap); seg tracks the selected nibble.
- Drop enable for 1 cycle while digit_sel=10 -> seg=00 and digit_sel=00 that cycle. On re-enable: digit_sel=01 for a full 4 clocks.
- WIDTH=5 instance, in0=1F, in1=00, opcode=01 -> result=1F. digit 0 seg=47 ('F'), digit 1 seg=30 ('1'), DIGITS=2.
